// File: rtl/act_pkg.sv
// Shared types for the activation stream unit: function select and per-tensor config.
package act_pkg;

  localparam int unsigned ACT_SHIFT_W = 3;
  localparam int unsigned ACT_CAP_W   = 32;

  typedef enum logic [1:0] {
    ACT_RELU  = 2'd0,
    ACT_LEAKY = 2'd1,
    ACT_CLIP  = 2'd2,
    ACT_IDENT = 2'd3
  } act_mode_e;

  // cap is zero-extended from the element width; lanes use only its low DATA_W-1 bits
  typedef struct packed {
    act_mode_e              mode;
    logic [ACT_SHIFT_W-1:0] shift;
    logic [ACT_CAP_W-1:0]   cap;
  } act_cfg_t;

endpackage

// File: rtl/act_stream_unit_if.sv
// Input and output beat streams of the activation unit, both valid/ready.
interface act_stream_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4
);

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic                      out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/act_lane.sv
// Single-element activation: ReLU, leaky ReLU (arithmetic shift), clipped ReLU or identity.
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] x,
  input  act_cfg_t                 cfg,
  output logic signed [DATA_W-1:0] y_c
);

  logic signed [DATA_W-1:0] cap_s;
  logic                     unused_cap;

  // Ceiling is always non-negative: top bit of the element width forced to zero
  assign cap_s      = $signed({1'b0, cfg.cap[DATA_W-2:0]});
  assign unused_cap = ^cfg.cap[ACT_CAP_W-1:DATA_W-1];

  always_comb begin
    y_c = x;
    case (cfg.mode)
      ACT_RELU: begin
        if (x < 0) y_c = '0;
      end
      ACT_LEAKY: begin
        if (x < 0) y_c = x >>> cfg.shift;
      end
      ACT_CLIP: begin
        if (x < 0)          y_c = '0;
        else if (x > cap_s) y_c = cap_s;
      end
      default: y_c = x;
    endcase
  end

endmodule

// File: rtl/act_stream_unit.sv
// Pipelined activation stage: config latch per tensor, 2-stage valid/ready pipe,
// last-beat tagging and per-tensor zero-output count.
module act_stream_unit
  import act_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned LANES    = 4,
  parameter  int unsigned CHANNELS = 1,
  parameter  int unsigned ROWS     = 1,
  parameter  int unsigned COLS     = 1,
  localparam int unsigned ZC_W     = $clog2(CHANNELS*ROWS*COLS+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         cfg_mode,
  input  logic [2:0]         cfg_shift,
  input  logic [DATA_W-1:0]  cfg_cap,
  act_stream_unit_if.slave   bus,
  output logic [ZC_W-1:0]    zero_count,
  output logic               zero_count_valid
);

  localparam int unsigned BEATS = CHANNELS*ROWS*COLS/LANES;
  localparam int unsigned BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LZ_W  = $clog2(LANES+1);
  localparam int unsigned BUS_W = LANES*DATA_W;

  if (COLS % LANES != 0) begin : g_cols_check
    $error("act_stream_unit: COLS must be a multiple of LANES");
  end

  logic [BC_W-1:0]  beat_cnt;
  logic             beat_last_c;
  act_cfg_t         cfg_in_c;
  act_cfg_t         cfg_q;
  act_cfg_t         cfg_use_c;
  logic [BUS_W-1:0] lane_y_c;
  logic             unused_cap_msb;

  logic             s1_valid, s1_last;
  logic [BUS_W-1:0] s1_data;
  logic [LZ_W-1:0]  s1_zeros_c;
  logic             s2_valid, s2_last;
  logic [BUS_W-1:0] s2_data;
  logic [LZ_W-1:0]  s2_zeros;
  logic [ZC_W-1:0]  zero_acc;

  logic s1_ready_c, s2_ready_c, in_fire_c, out_fire_c;

  // Each stage accepts when empty or when its successor is draining
  assign s2_ready_c = !s2_valid || bus.out_ready;
  assign s1_ready_c = !s1_valid || s2_ready_c;
  assign in_fire_c  = bus.in_valid && s1_ready_c;
  assign out_fire_c = s2_valid && bus.out_ready;

  assign bus.in_ready  = s1_ready_c;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_last  = s2_last;

  assign beat_last_c    = (beat_cnt == BC_W'(BEATS-1));
  assign unused_cap_msb = cfg_cap[DATA_W-1];

  always_comb begin
    cfg_in_c       = '0;
    cfg_in_c.mode  = act_mode_e'(cfg_mode);
    cfg_in_c.shift = cfg_shift;
    cfg_in_c.cap   = ACT_CAP_W'(cfg_cap[DATA_W-2:0]);
  end

  // First beat of a tensor uses live config; later beats use the latched copy
  assign cfg_use_c = (beat_cnt == '0) ? cfg_in_c : cfg_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(.DATA_W(DATA_W)) u_lane (
      .x   (bus.in_data[i*DATA_W +: DATA_W]),
      .cfg (cfg_use_c),
      .y_c (lane_y_c[i*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    s1_zeros_c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_data[i*DATA_W +: DATA_W] == '0) s1_zeros_c = s1_zeros_c + LZ_W'(1);
    end
  end

  // Beat position within the tensor and config latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      cfg_q    <= '0;
    end else if (in_fire_c) begin
      beat_cnt <= beat_last_c ? '0 : beat_cnt + BC_W'(1);
      if (beat_cnt == '0) cfg_q <= cfg_in_c;
    end
  end

  // S1 holds activated lanes, S2 is the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
      s2_zeros <= '0;
    end else begin
      if (s1_ready_c) begin
        s1_valid <= bus.in_valid;
        if (in_fire_c) begin
          s1_data <= lane_y_c;
          s1_last <= beat_last_c;
        end
      end
      if (s2_ready_c) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data  <= s1_data;
          s2_last  <= s1_last;
          s2_zeros <= s1_zeros_c;
        end
      end
    end
  end

  // Zero accumulation restarts on the same edge that publishes the finished tensor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc         <= '0;
      zero_count       <= '0;
      zero_count_valid <= 1'b0;
    end else begin
      zero_count_valid <= 1'b0;
      if (out_fire_c) begin
        if (s2_last) begin
          zero_count       <= zero_acc + ZC_W'(s2_zeros);
          zero_count_valid <= 1'b1;
          zero_acc         <= '0;
        end else begin
          zero_acc <= zero_acc + ZC_W'(s2_zeros);
        end
      end
    end
  end

endmodule

// File: tb/tb_act_stream_unit.sv
// Directed bench for act_stream_unit: table of single-config tensors plus
// backpressure, mid-tensor config change, back-to-back tensors and mid-tensor reset.
module tb_act_stream_unit;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned LANES    = 4;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned ROWS     = 2;
  localparam int unsigned COLS     = 4;
  localparam int unsigned ZC_W     = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       cfg_mode;
  logic [2:0]       cfg_shift;
  logic [7:0]       cfg_cap;
  logic [ZC_W-1:0]  zero_count;
  logic             zero_count_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  act_stream_unit_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  act_stream_unit #(
    .DATA_W(DATA_W), .LANES(LANES), .CHANNELS(CHANNELS), .ROWS(ROWS), .COLS(COLS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_mode         (cfg_mode),
    .cfg_shift        (cfg_shift),
    .cfg_cap          (cfg_cap),
    .bus              (bus),
    .zero_count       (zero_count),
    .zero_count_valid (zero_count_valid)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  shift;
    logic [7:0]  cap;
    logic [31:0] x;
    logic [31:0] y;
    int          zc;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } obs_t;

  vec_t        vt[9];
  obs_t        oq[$];
  int          zq[$];
  logic [31:0] ed[$];
  logic        el[$];
  int          ez[$];

  logic        prev_stall = 1'b0;
  logic        prev_zcv   = 1'b0;
  logic [31:0] prev_d     = '0;
  logic        prev_l     = 1'b0;

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [31:0] r;
    r[7:0]   = a[7:0];
    r[15:8]  = b[7:0];
    r[23:16] = c[7:0];
    r[31:24] = d[7:0];
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input logic [2:0] s, input logic [7:0] c,
                              input logic [31:0] x, input logic [31:0] y, input int zc);
    vec_t v;
    v.mode = m; v.shift = s; v.cap = c; v.x = x; v.y = y; v.zc = zc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output observer: records handshakes and zero-count pulses, checks hold under stall
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_zcv   <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_data", 64'(bus.out_data), 64'(prev_d));
        chk("stall_last", 64'(bus.out_last), 64'(prev_l));
      end
      if (bus.out_valid && bus.out_ready) oq.push_back('{bus.out_data, bus.out_last});
      if (zero_count_valid) begin
        chk("zcv_single_cycle", 64'(prev_zcv), 64'(0));
        zq.push_back(int'(zero_count));
      end
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_d     <= bus.out_data;
      prev_l     <= bus.out_last;
      prev_zcv   <= zero_count_valid;
    end
  end

  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=low_for_%0d_cycles required=high", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic l);
    ed.push_back(d);
    el.push_back(l);
  endtask

  task automatic drain();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_nbeats"}, 64'(oq.size()), 64'(ed.size()));
    for (int i = 0; i < ed.size() && i < oq.size(); i++) begin
      chk({tag, "_data"}, 64'(oq[i].d), 64'(ed[i]));
      chk({tag, "_last"}, 64'(oq[i].l), 64'(el[i]));
    end
    chk({tag, "_nzc"}, 64'(zq.size()), 64'(ez.size()));
    for (int i = 0; i < ez.size() && i < zq.size(); i++)
      chk({tag, "_zero_count"}, 64'(zq[i]), 64'(ez[i]));
    oq.delete(); zq.delete(); ed.delete(); el.delete(); ez.delete();
  endtask

  initial begin
    // mode, shift, cap, input lanes 0..3, expected lanes 0..3, zeros per 4-beat tensor
    vt[0] = mk(2'd0, 3'd0, 8'd0,   pack4(-128, -1, 0, 127),  pack4(0, 0, 0, 127),     12);
    vt[1] = mk(2'd1, 3'd3, 8'd0,   pack4(-8, -1, -9, 5),     pack4(-1, -1, -2, 5),    0);
    vt[2] = mk(2'd2, 3'd0, 8'd6,   pack4(-3, 6, 7, 100),     pack4(0, 6, 6, 6),       4);
    vt[3] = mk(2'd3, 3'd5, 8'd9,   pack4(-5, 0, 0, 3),       pack4(-5, 0, 0, 3),      8);
    vt[4] = mk(2'd2, 3'd0, 8'hFF,  pack4(-128, 127, 126, 0), pack4(0, 127, 126, 0),   8);
    vt[5] = mk(2'd1, 3'd0, 8'd0,   pack4(-7, -1, 2, 0),      pack4(-7, -1, 2, 0),     4);
    vt[6] = mk(2'd1, 3'd7, 8'd0,   pack4(-128, -1, -127, 1), pack4(-1, -1, -1, 1),    0);
    vt[7] = mk(2'd2, 3'd0, 8'd0,   pack4(5, -5, 0, 1),       pack4(0, 0, 0, 0),       16);
    vt[8] = mk(2'd0, 3'd2, 8'd50,  pack4(1, -2, 3, -4),      pack4(1, 0, 3, 0),       8);

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    cfg_mode = 2'd0; cfg_shift = 3'd0; cfg_cap = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_zero_count", 64'(zero_count), 64'(0));
    chk("rst_zcv", 64'(zero_count_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: one full tensor of identical beats per record
    for (int v = 0; v < 9; v++) begin
      cfg_mode = vt[v].mode; cfg_shift = vt[v].shift; cfg_cap = vt[v].cap;
      for (int b = 0; b < 4; b++) begin
        send_beat(vt[v].x);
        exp_beat(vt[v].y, b == 3);
      end
      ez.push_back(vt[v].zc);
      drain();
      compare_all($sformatf("vec%0d", v));
    end

    // Backpressure: ready toggles, then a 5-cycle hold-off, across two tensors
    cfg_mode = 2'd3;
    fork
      begin
        for (int k = 0; k < 8; k++) send_beat(pack4(4*k+1, 4*k+2, 4*k+3, 0));
      end
      begin
        for (int i = 0; i < 8; i++) begin
          bus.out_ready = (i % 2 == 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 8; k++) exp_beat(pack4(4*k+1, 4*k+2, 4*k+3, 0), (k == 3) || (k == 7));
    ez.push_back(4); ez.push_back(4);
    drain();
    compare_all("bp");

    // Mode change after beat 2 only affects the following tensor
    cfg_mode = 2'd0;
    send_beat(pack4(-1, 2, -3, 4));
    send_beat(pack4(-1, 2, -3, 4));
    cfg_mode = 2'd3;
    for (int k = 0; k < 6; k++) send_beat(pack4(-1, 2, -3, 4));
    for (int k = 0; k < 4; k++) exp_beat(pack4(0, 2, 0, 4), k == 3);
    for (int k = 0; k < 4; k++) exp_beat(pack4(-1, 2, -3, 4), k == 3);
    ez.push_back(8); ez.push_back(0);
    drain();
    compare_all("cfgchg");

    // Back-to-back tensors: all zero, then all positive
    cfg_mode = 2'd0;
    for (int k = 0; k < 4; k++) send_beat(pack4(0, 0, 0, 0));
    for (int k = 0; k < 4; k++) send_beat(pack4(1, 2, 3, 4));
    for (int k = 0; k < 4; k++) exp_beat(pack4(0, 0, 0, 0), k == 3);
    for (int k = 0; k < 4; k++) exp_beat(pack4(1, 2, 3, 4), k == 3);
    ez.push_back(16); ez.push_back(0);
    drain();
    compare_all("b2b");

    // Reset with one beat already counted and one on the output
    cfg_mode = 2'd0;
    send_beat(pack4(-1, -1, -1, -1));
    send_beat(pack4(-1, -1, -1, -1));
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_out_data", 64'(bus.out_data), 64'(0));
    chk("mid_rst_out_last", 64'(bus.out_last), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("mid_rst_zero_count", 64'(zero_count), 64'(0));
    exp_beat(pack4(0, 0, 0, 0), 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cfg_mode = 2'd3;
    for (int k = 0; k < 4; k++) send_beat(pack4(0, -1, 5, 0));
    for (int k = 0; k < 4; k++) exp_beat(pack4(0, -1, 5, 0), k == 3);
    ez.push_back(8);
    drain();
    compare_all("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
